// File: rtl/lut_bank.sv
// lut_bank: bank of serially configured LUTs with per-LUT combinational or registered output
module lut_bank #(
   parameter int WIDTH    = 4,
   parameter int NUM_LUTS = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_cfg,
   input  logic                i_cfg_tdata,
   input  logic                i_cfg_tvalid,
   input  logic                i_cfg_tlast,
   output logic                o_cfg_tready,
   output logic                o_cfg_ready,
   output logic                o_cfg_error,
   input  logic                i_run,
   input  logic [WIDTH-1:0]    i_run_in,
   output logic [NUM_LUTS-1:0] o_run_out
);
   localparam int DEPTH    = 1 << WIDTH;
   localparam int CFG_BITS = NUM_LUTS * (DEPTH + 1);
   localparam int CW       = $clog2(CFG_BITS);
   typedef enum logic [2:0] {S_INIT, S_LOAD, S_IDLE, S_RUN, S_ERROR} state_t;
   state_t                r_state;
   state_t                w_next;
   logic [CFG_BITS-1:0]   r_cfg;
   logic [CW-1:0]         r_cnt;
   logic [NUM_LUTS-1:0]   r_flop;
   logic                  r_cfg_ready;
   logic                  r_cfg_error;
   logic [NUM_LUTS-1:0]   w_sel;
   logic [NUM_LUTS-1:0]   w_mode;
   logic                  w_beat;
   logic                  w_last_k;
   assign o_cfg_tready = r_state == S_LOAD;
   assign w_beat       = i_cfg_tvalid && o_cfg_tready;
   assign w_last_k     = r_cnt == CW'(CFG_BITS - 1);
   assign o_cfg_ready  = r_cfg_ready;
   assign o_cfg_error  = r_cfg_error;
   for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
      logic [DEPTH-1:0] w_tbl;
      assign w_tbl     = r_cfg[i*(DEPTH+1) +: DEPTH];
      assign w_mode[i] = r_cfg[i*(DEPTH+1) + DEPTH];
      assign w_sel[i]  = w_tbl[i_run_in];
   end
   // registered LUTs show their flop in RUN and IDLE; combinational LUTs only drive in RUN
   assign o_run_out = (w_mode & ((r_state == S_RUN || r_state == S_IDLE) ? r_flop : '0))
                    | (~w_mode & ((r_state == S_RUN) ? w_sel : '0));
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT, S_ERROR: w_next = i_cfg ? S_LOAD : r_state;
         S_LOAD:          w_next = !w_beat ? S_LOAD
                                 : (w_last_k && i_cfg_tlast) ? S_IDLE
                                 : (w_last_k || i_cfg_tlast) ? S_ERROR : S_LOAD;
         S_IDLE:          w_next = i_run ? S_RUN : S_IDLE;
         S_RUN:           w_next = i_run ? S_RUN : i_cfg ? S_LOAD : S_IDLE;
         default:         w_next = S_INIT;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_INIT;
         r_cfg       <= '0;
         r_cnt       <= '0;
         r_flop      <= '0;
         r_cfg_ready <= 1'b0;
         r_cfg_error <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_RUN)
            r_flop <= w_sel;
         if (w_beat) begin
            r_cfg[r_cnt] <= i_cfg_tdata;
            r_cnt        <= w_last_k ? '0 : r_cnt + 1'b1;
            r_cfg_ready  <= w_next == S_IDLE;
            r_cfg_error  <= w_next == S_ERROR;
         end
         // a fresh load starts from a clean slate; tables are overwritten beat by beat
         if (w_next == S_LOAD && r_state != S_LOAD) begin
            r_cnt       <= '0;
            r_flop      <= '0;
            r_cfg_ready <= 1'b0;
            r_cfg_error <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_lut_bank.sv
// tb_lut_bank: scoreboard bench for lut_bank with WIDTH=2, NUM_LUTS=2
module tb_lut_bank;
   localparam int OUT = 0, RDY = 1, ERR = 2, TRDY = 3;
   // LUT0=AND mode0, LUT1=XOR mode1
   localparam logic [9:0] CFG_A = 10'b1_0110_0_1000;
   // LUT0=OR mode1, LUT1=NAND mode0
   localparam logic [9:0] CFG_C = 10'b0_0111_1_1110;
   logic       clk = 0, rst_n = 0, cfg = 0, tdata = 0, tvalid = 0, tlast = 0, run = 0;
   logic [1:0] run_in = 0;
   logic       tready, cfg_ready, cfg_error;
   logic [1:0] run_out;
   typedef struct {int cyc; int f; logic [1:0] v; string nm;} exp_t;
   exp_t q[$];
   int cyc = 0, checks = 0, errors = 0;
   lut_bank #(.WIDTH(2), .NUM_LUTS(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg(cfg), .i_cfg_tdata(tdata),
      .i_cfg_tvalid(tvalid), .i_cfg_tlast(tlast), .o_cfg_tready(tready),
      .o_cfg_ready(cfg_ready), .o_cfg_error(cfg_error), .i_run(run),
      .i_run_in(run_in), .o_run_out(run_out)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [1:0] act(input int f);
      return f == OUT ? run_out : f == RDY ? {1'b0, cfg_ready} : f == ERR ? {1'b0, cfg_error} : {1'b0, tready};
   endfunction
   always @(negedge clk) begin : mon
      exp_t keep[$];
      keep = {};
      foreach (q[j]) begin
         if (q[j].cyc == cyc) begin
            checks++;
            if (act(q[j].f) !== q[j].v) begin
               errors++;
               $display("FAIL %s at cycle %0d: got %0d expected %0d", q[j].nm, cyc, act(q[j].f), q[j].v);
            end
         end else keep.push_back(q[j]);
      end
      q = keep;
   end
   task automatic chk(input string nm, input int f, input logic [1:0] v);
      q.push_back('{cyc, f, v, nm});
   endtask
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send_frame(input logic [9:0] v, input int n, input int last_at, input bit stall);
      for (int k = 0; k < n; k++) begin
         int t;
         logic hs;
         if (stall) begin
            tvalid = 0;
            step(2);
         end
         tvalid = 1;
         tdata  = v[k];
         tlast  = (k == last_at);
         if (k == n - 1) chk("ready_before_last", RDY, 2'd0);
         t = 0;
         do begin
            @(negedge clk);
            hs = tready;
            @(posedge clk);
            #1;
            t++;
         end while (!hs && t < 20);
         if (!hs) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout beat %0d: got tready=0 expected 1", k);
         end
      end
      tvalid = 0;
      tlast  = 0;
   endtask
   task automatic run_burst(input logic [7:0] ins, input logic [1:0] pre, input logic [7:0] ex, input logic [1:0] idle);
      chk("pre_run", OUT, pre);
      run    = 1;
      run_in = ins[1:0];
      step;
      for (int j = 0; j < 4; j++) begin
         run_in = ins[2*j +: 2];
         if (j == 3) run = 0;
         chk($sformatf("run_out_%0d", j), OUT, ex[2*j +: 2]);
         step;
      end
      chk("idle_hold", OUT, idle);
   endtask
   task automatic enter_load_from_idle;
      run = 1;
      step;
      run = 0;
      cfg = 1;
      step;
      cfg = 0;
      chk("load_tready", TRDY, 2'd1);
      chk("load_out0", OUT, 2'd0);
      chk("load_ready0", RDY, 2'd0);
   endtask
   task automatic offer_blocked;
      tvalid = 1;
      repeat (3) begin
         chk("held_off", TRDY, 2'd0);
         step;
      end
      tvalid = 0;
   endtask
   task automatic loaded_ok;
      chk("cfg_ready", RDY, 2'd1);
      chk("cfg_error0", ERR, 2'd0);
      chk("tready_off", TRDY, 2'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      step(2);
      chk("rst_out", OUT, 2'd0);
      chk("rst_ready", RDY, 2'd0);
      chk("rst_error", ERR, 2'd0);
      chk("rst_tready", TRDY, 2'd0);
      rst_n = 1;
      step;
      chk("init_tready", TRDY, 2'd0);
      cfg = 1;
      step;
      cfg = 0;
      chk("load_tready", TRDY, 2'd1);
      send_frame(CFG_A, 10, 9, 0);
      loaded_ok();
      run_burst(8'b00_10_01_11, 2'b00, 8'b10_10_00_01, 2'b00);
      run_burst(8'b01_01_01_01, 2'b00, 8'b10_10_10_00, 2'b10);
      cfg = 1;
      step;
      cfg = 0;
      chk("idle_cfg_ignored", TRDY, 2'd0);
      chk("idle_still_held", OUT, 2'b10);
      // run and cfg together keep the bank running
      run = 1;
      cfg = 1;
      run_in = 3;
      step;
      chk("run_cfg_out_a", OUT, 2'b11);
      chk("run_cfg_tready_a", TRDY, 2'd0);
      step;
      chk("run_cfg_out_b", OUT, 2'b01);
      chk("run_cfg_tready_b", TRDY, 2'd0);
      run = 0;
      step;
      cfg = 0;
      chk("reload_tready", TRDY, 2'd1);
      chk("reload_out0", OUT, 2'd0);
      chk("reload_ready0", RDY, 2'd0);
      send_frame(CFG_C, 10, 9, 0);
      loaded_ok();
      run_burst(8'b11_10_01_00, 2'b00, 8'b01_11_10_10, 2'b01);
      // premature tlast on beat 4
      enter_load_from_idle();
      send_frame(CFG_A, 5, 4, 0);
      chk("early_error", ERR, 2'd1);
      chk("early_ready", RDY, 2'd0);
      chk("early_out", OUT, 2'd0);
      offer_blocked();
      cfg = 1;
      step;
      cfg = 0;
      chk("err_cleared", ERR, 2'd0);
      send_frame(CFG_A, 10, 9, 1);
      loaded_ok();
      run_burst(8'b00_10_01_11, 2'b00, 8'b10_10_00_01, 2'b00);
      // missing tlast on beat 9
      enter_load_from_idle();
      send_frame(CFG_A, 10, -1, 0);
      chk("notlast_error", ERR, 2'd1);
      chk("notlast_ready", RDY, 2'd0);
      chk("notlast_out", OUT, 2'd0);
      offer_blocked();
      // reset in the middle of a load
      cfg = 1;
      step;
      cfg = 0;
      send_frame(CFG_A, 6, -1, 0);
      chk("midload_tready", TRDY, 2'd1);
      rst_n = 0;
      step;
      rst_n = 1;
      chk("midrst_ready", RDY, 2'd0);
      chk("midrst_error", ERR, 2'd0);
      chk("midrst_out", OUT, 2'd0);
      chk("midrst_tready", TRDY, 2'd0);
      step;
      cfg = 1;
      step;
      cfg = 0;
      send_frame(CFG_C, 10, 9, 0);
      loaded_ok();
      run_burst(8'b11_10_01_00, 2'b00, 8'b01_11_10_10, 2'b01);
      step(3);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_checks: got %0d expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
